// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one external W-bit adder between two requesters. A round-robin
//   arbiter picks a requester in IDLE and latches its operands. The block
//   then presents them to the external adder for one cycle (ISSUE) and
//   registers the returned sum. The sum is offered as a one-cycle result
//   (RESP), after which the block returns to IDLE.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req0, req1   level request from requester 0 / 1
//   x0, y0       operands of requester 0 (stable while req0 is high)
//   x1, y1       operands of requester 1 (stable while req1 is high)
//   gnt0, gnt1   one-cycle pulse: operands of requester N were accepted
//   done0, done1 one-cycle pulse: res holds requester N's sum
//   res          registered W+1-bit sum, carry in bit W
//   add_x, add_y operands driven to the external adder
//   add_z        combinational W+1-bit sum returned by the external adder
//   busy         high while an operation is in flight (not IDLE)

module adder_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W:0]   res,
    output logic [W-1:0] add_x,
    output logic [W-1:0] add_y,
    input  logic [W:0]   add_z,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         rr;
    logic         owner;
    logic         winner;
    logic         any_req;
    logic [W-1:0] op_x;
    logic [W-1:0] op_y;

    // Round-robin choice: rr only decides a tie. A lone requester wins
    // whatever rr says, so winner simply follows req1 in that case.
    always_comb begin
        any_req = req0 | req1;
        winner  = 1'b0;
        if (req0 && req1) begin
            winner = rr;
        end else begin
            winner = req1;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE, so any request
    // change during ISSUE/RESP is ignored, and a request still held through
    // RESP is seen again as a fresh request in the following IDLE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, arbitration pointer, operand latch and result register.
    // The operand registers only change on a grant, so the external adder
    // sees the granted operands even if the requester changes its inputs.
    // The sum is captured at the end of ISSUE and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr    <= 1'b0;
            owner <= 1'b0;
            op_x  <= '0;
            op_y  <= '0;
            res   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                op_x  <= winner ? x1 : x0;
                op_y  <= winner ? y1 : y0;
                owner <= winner;
                rr    <= ~winner;
            end
            if (state == ISSUE) begin
                res <= add_z;
            end
        end
    end

    // Outputs decode straight from the registered state, so reset clears
    // them immediately without waiting for a clock edge.
    assign gnt0  = (state == ISSUE) && !owner;
    assign gnt1  = (state == ISSUE) &&  owner;
    assign done0 = (state == RESP)  && !owner;
    assign done1 = (state == RESP)  &&  owner;
    assign busy  = (state != IDLE);
    assign add_x = op_x;
    assign add_y = op_y;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning operand width of the shared adder.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port req0 / req1  input  1 each  requester 0/1 operation request, level.
REQ-005 Port x0, y0 / x1, y1  input  W each  requester 0/1 operands, held stable while reqN is high.
REQ-006 Port gnt0 / gnt1  output  1 each  one-cycle pulse: operands of requester N were accepted.
REQ-007 Port done0 / done1  output  1 each  one-cycle pulse: res is valid for requester N.
REQ-008 Port res  output  W+1  registered sum, shared by both requesters, carry in bit W.
REQ-009 Port add_x, add_y  output  W each  operands driven to the external shared adder.
REQ-010 Port add_z  input  W+1  combinational sum returned from the external adder.
REQ-011 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM SHALL have three states: IDLE, ISSUE, RESP; encoding free.
REQ-013 IDLE: no req -> stay; any req -> select winner, load op registers from winner's x/y, record owner, go ISSUE.
REQ-014 Arbitration SHALL be round-robin: both requesting -> grant the requester indicated by pointer rr; only one requesting -> grant it regardless of rr.
REQ-015 On each grant rr SHALL move to the non-granted requester (after granting 0, rr=1; after granting 1, rr=0).
REQ-016 gnt of the owner SHALL be high for exactly the ISSUE cycle; never both gnt high.
REQ-017 add_x/add_y SHALL be driven from the op registers at all times; op registers change only on a grant.
REQ-018 ISSUE: at the clock edge capture add_z into res, go RESP.
REQ-019 RESP: done of the owner high for exactly this cycle; next edge -> IDLE unconditionally.
REQ-020 Latency: req sampled high in IDLE cycle N -> gnt in N+1 -> done with valid res in N+2; back in IDLE at N+3; next gnt no earlier than N+4.
REQ-021 req sampled only in IDLE; req changes during ISSUE/RESP SHALL have no effect.
REQ-022 Requester keeping req high through RESP SHALL be treated as a new request in the following IDLE cycle.
REQ-023 res SHALL hold its value until the next ISSUE capture; no arithmetic inside the block (sum width W+1, no truncation).
REQ-024 busy SHALL be high in ISSUE and RESP, low in IDLE.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, rr=0, op registers=0, res=0, gnt0/1=0, done0/1=0, busy=0, independent of clk.
REQ-026 Reset asserted in ISSUE or RESP SHALL abort the operation; no done pulse SHALL follow for it.
REQ-027 After rst_n deassertion the first IDLE cycle SHALL arbitrate with rr=0 (requester 0 preferred).

Verification
REQ-028 W=4, req0=1 x0=8 y0=3 only -> gnt0 one cycle later, done0 next cycle with res=11, gnt1/done1 stay 0.
REQ-029 req0 and req1 high together after reset, x0=4 y0=4, x1=3 y1=7, both held -> gnt0/done0 res=8 first, then gnt1/done1 res=10; alternation continues while both high.
REQ-030 req1 alone x1=15 y1=15 -> done1 with res=30 (bit 4 set); next simultaneous request grants requester 0 first.
REQ-031 req0 x0=2 y0=5, change x0 to 9 during ISSUE -> res=7; add_x stays 2 until next grant.
REQ-032 rst_n pulsed low during ISSUE -> all outputs 0 asynchronously, no done pulse, busy=0, next arbitration prefers requester 0.
REQ-033 Random traffic: check every done matches exactly one prior gnt of same requester, res equals x+y of that grant, and gnt never arrives while busy was high the cycle before.
